// File: rtl/countdown_mmss.sv
// BCD mm:ss down-counter with done pulse and timed alarm for timer mode.
// Optional COUNTDOWN_RELOAD_EN: auto-reload the last preset on expiry.
module countdown_mmss #(
    parameter int ALARM_TICKS = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       clear,
    input  logic       load,
    input  logic [3:0] ld_min_H,
    input  logic [3:0] ld_min_L,
    input  logic [3:0] ld_sec_H,
    input  logic [3:0] ld_sec_L,
    input  logic       start,
    input  logic       pause,
    output logic [3:0] min_H,
    output logic [3:0] min_L,
    output logic [3:0] sec_H,
    output logic [3:0] sec_L,
    output logic       running,
    output logic       done,
    output logic       alarm
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(ALARM_TICKS - 1);

    state_t      state;
    state_t      n_state;
    logic [15:0] digits;
    logic [15:0] n_digits;
    logic [15:0] dec;
    logic [15:0] preset;
    logic [3:0]  cnt;
    logic [3:0]  n_cnt;
    logic        n_done;
    logic        n_alarm;
    logic        expiring;

`ifdef COUNTDOWN_RELOAD_EN
    logic [15:0] reload;
    logic [15:0] n_reload;
`endif

    function automatic logic [3:0] clamp_u(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    function automatic logic [3:0] clamp_t(input logic [3:0] d);
        return (d > 4'd5) ? 4'd5 : d;
    endfunction

    assign {min_H, min_L, sec_H, sec_L} = digits;

    assign preset = {clamp_t(ld_min_H), clamp_u(ld_min_L),
                     clamp_t(ld_sec_H), clamp_u(ld_sec_L)};

    assign expiring = (digits == 16'h0001);

    // Borrow ripples from seconds units up to minutes tens.
    always_comb begin
        dec = digits;
        if (digits[3:0] != 4'd0) begin
            dec[3:0] = digits[3:0] - 4'd1;
        end else begin
            dec[3:0] = 4'd9;
            if (digits[7:4] != 4'd0) begin
                dec[7:4] = digits[7:4] - 4'd1;
            end else begin
                dec[7:4] = 4'd5;
                if (digits[11:8] != 4'd0) begin
                    dec[11:8] = digits[11:8] - 4'd1;
                end else begin
                    dec[11:8]  = 4'd9;
                    dec[15:12] = digits[15:12] - 4'd1;
                end
            end
        end
    end

    always_comb begin
        n_state  = state;
        n_digits = digits;
        n_cnt    = cnt;
        n_done   = 1'b0;
        n_alarm  = alarm;
`ifdef COUNTDOWN_RELOAD_EN
        n_reload = reload;
`endif
        if (clear) begin
            n_state  = IDLE;
            n_digits = 16'h0000;
            n_alarm  = 1'b0;
            n_cnt    = 4'd0;
        end else if (load && state != RUN) begin
            n_state  = IDLE;
            n_digits = preset;
            n_alarm  = 1'b0;
            n_cnt    = 4'd0;
`ifdef COUNTDOWN_RELOAD_EN
            n_reload = preset;
`endif
        end else if (start && (state == IDLE || state == PAUSE)) begin
            if (digits != 16'h0000) begin
                n_state = RUN;
            end
        end else if (pause && state == RUN) begin
            n_state = PAUSE;
        end else if (tick) begin
            if (state == RUN) begin
                if (expiring) begin
                    n_done = 1'b1;
`ifdef COUNTDOWN_RELOAD_EN
                    if (reload != 16'h0000) begin
                        n_digits = reload;
                    end else begin
                        n_digits = 16'h0000;
                        n_state  = DONE;
                        n_alarm  = 1'b1;
                        n_cnt    = 4'd0;
                    end
`else
                    n_digits = 16'h0000;
                    n_state  = DONE;
                    n_alarm  = 1'b1;
                    n_cnt    = 4'd0;
`endif
                end else begin
                    n_digits = dec;
                end
            end else if (state == DONE) begin
                if (cnt >= LAST_CNT) begin
                    n_state = IDLE;
                    n_alarm = 1'b0;
                    n_cnt   = 4'd0;
                end else begin
                    n_cnt = cnt + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            digits  <= 16'h0000;
            cnt     <= 4'd0;
            done    <= 1'b0;
            alarm   <= 1'b0;
            running <= 1'b0;
        end else begin
            state   <= n_state;
            digits  <= n_digits;
            cnt     <= n_cnt;
            done    <= n_done;
            alarm   <= n_alarm;
            running <= (n_state == RUN);
        end
    end

`ifdef COUNTDOWN_RELOAD_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reload <= 16'h0000;
        end else begin
            reload <= n_reload;
        end
    end
`endif

endmodule

// File: tb/tb_countdown_mmss.sv
// Directed bench for countdown_mmss: expiry, borrows, clamping,
// pause/resume, async reset and the optional reload mode.
module tb_countdown_mmss;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       clear = 1'b0;
    logic       load = 1'b0;
    logic [3:0] ld_min_H = '0;
    logic [3:0] ld_min_L = '0;
    logic [3:0] ld_sec_H = '0;
    logic [3:0] ld_sec_L = '0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic [3:0] min_H, min_L, sec_H, sec_L;
    logic       running, done, alarm;

    int tests = 0;
    int fails = 0;

    countdown_mmss #(.ALARM_TICKS(5)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .clear(clear),
        .load(load), .ld_min_H(ld_min_H), .ld_min_L(ld_min_L),
        .ld_sec_H(ld_sec_H), .ld_sec_L(ld_sec_L),
        .start(start), .pause(pause),
        .min_H(min_H), .min_L(min_L), .sec_H(sec_H), .sec_L(sec_L),
        .running(running), .done(done), .alarm(alarm)
    );

    always #5 clk = ~clk;

    wire [15:0] dig = {min_H, min_L, sec_H, sec_L};

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic do_load(input logic [15:0] v);
        {ld_min_H, ld_min_L, ld_sec_H, ld_sec_L} = v;
        load = 1'b1;
        cyc();
        load = 1'b0;
    endtask

    initial begin
        cyc();
        cyc();
        check("rst_digits", dig, 16'h0000);
        check("rst_flags", {13'd0, running, done, alarm}, 16'h0000);
        rst_n = 1'b1;
        cyc();

        // Expiry from 00:03
        do_load(16'h0003);
        check("ld3", dig, 16'h0003);
        do_start();
        check("run3", {15'd0, running}, 16'h0001);
        do_tick();
        check("t_0002", dig, 16'h0002);
        do_tick();
        check("t_0001", dig, 16'h0001);
        do_tick();
`ifdef COUNTDOWN_RELOAD_EN
        check("rl_digits", dig, 16'h0003);
        check("rl_flags", {13'd0, running, done, alarm}, 16'h0006);
        do_clear();
`else
        check("exp_digits", dig, 16'h0000);
        check("exp_flags", {13'd0, running, done, alarm}, 16'h0003);
        cyc();
        check("done_1cyc", {13'd0, running, done, alarm}, 16'h0001);
        for (int i = 0; i < 4; i++) do_tick();
        check("alarm_4t", {15'd0, alarm}, 16'h0001);
        do_tick();
        check("alarm_5t", {15'd0, alarm}, 16'h0000);
        do_tick();
        check("done_floor", dig, 16'h0000);
        do_start();
        check("start_zero", {13'd0, running, done, alarm}, 16'h0000);
`endif

        // Full borrow chains
        do_load(16'h1000);
        do_start();
        do_tick();
        check("b_0959", dig, 16'h0959);
        do_clear();
        check("clr", dig, 16'h0000);
        do_load(16'h0100);
        do_start();
        do_tick();
        check("b_0059", dig, 16'h0059);

        // Clamping
        do_clear();
        do_load(16'hFA7C);
        check("clamp", dig, 16'h5959);
        do_start();
        do_tick();
        check("c_5958", dig, 16'h5958);

        // Pause / resume
        do_clear();
        do_load(16'h0010);
        do_start();
        pause = 1'b1;
        tick = 1'b1;
        cyc();
        pause = 1'b0;
        tick = 1'b0;
        check("p_dig", dig, 16'h0010);
        check("p_run", {15'd0, running}, 16'h0000);
        do_tick();
        do_tick();
        check("p_hold", dig, 16'h0010);
        do_start();
        check("resume", {15'd0, running}, 16'h0001);
        do_tick();
        check("r_0009", dig, 16'h0009);
        do_load(16'h0030);
        check("ld_in_run", dig, 16'h0009);
        check("ld_run_st", {15'd0, running}, 16'h0001);

        // Async reset mid-count
        do_clear();
        do_load(16'h0130);
        do_start();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_dig", dig, 16'h0000);
        check("arst_flags", {13'd0, running, done, alarm}, 16'h0000);
        cyc();
        rst_n = 1'b1;
        do_tick();
        do_tick();
        check("post_rst", {dig[12:0], running, done, alarm},
              16'h0000);

`ifdef COUNTDOWN_RELOAD_EN
        do_load(16'h0002);
        do_start();
        do_tick();
        do_tick();
        check("rl2_dig", dig, 16'h0002);
        check("rl2_flags", {13'd0, running, done, alarm}, 16'h0006);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
